// File: rtl/key_event_sequencer.sv
// PS/2 set-2 byte parser plus injection arbiter feeding a rate-limited event queue
// that drives the Oric keyboard matrix strobe interface.
module key_event_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned PREFIX_TIMEOUT = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  input  logic       inj_valid,
  input  logic [7:0] inj_code,
  input  logic       inj_pressed,
  input  logic       inj_extended,
  output logic       inj_ready,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(PREFIX_TIMEOUT + 1);

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       extended;
  } key_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } parse_state_t;

  parse_state_t     state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             live_ev;
  key_event_t       live_data;

  // Parser next-state: one decision per received byte, prefix timeout otherwise
  always_comb begin
    state_d            = state_q;
    skip_d             = skip_q;
    tmo_d              = tmo_q;
    live_ev            = 1'b0;
    live_data.code     = ps2_data;
    live_data.pressed  = 1'b1;
    live_data.extended = 1'b0;
    if (ps2_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (ps2_data)
            8'hE0: state_d = ST_E0;
            8'hF0: state_d = ST_F0;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
              state_d = ST_IDLE;
            end
            default: live_ev = 1'b1;
          endcase
        end
        ST_E0: begin
          if (ps2_data == 8'hF0) begin
            state_d = ST_E0F0;
          end else if (ps2_data != 8'hE0) begin
            live_ev            = 1'b1;
            live_data.extended = 1'b1;
            state_d            = ST_IDLE;
          end
        end
        ST_F0: begin
          live_ev           = 1'b1;
          live_data.pressed = 1'b0;
          state_d           = ST_IDLE;
        end
        ST_E0F0: begin
          live_ev            = 1'b1;
          live_data.pressed  = 1'b0;
          live_data.extended = 1'b1;
          state_d            = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_W'(PREFIX_TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  key_event_t       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [GAP_W-1:0] gap_q;
  logic             fifo_empty, fifo_full;
  logic             pop_c, live_push, inj_push, push;
  key_event_t       inj_data, push_data, head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_c      = !fifo_empty && (gap_q == '0);
  assign head       = mem[rd_ptr[PTR_W-1:0]];

  // Live events win; a pop in the same cycle frees a slot for them even when full
  assign live_push  = live_ev && (!fifo_full || pop_c);
  assign inj_ready  = !fifo_full && !live_ev && !reset;
  assign inj_push   = inj_valid && inj_ready;
  assign push       = live_push || inj_push;

  assign inj_data.code     = inj_code;
  assign inj_data.pressed  = inj_pressed;
  assign inj_data.extended = inj_extended;
  assign push_data         = live_ev ? live_data : inj_data;

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  // Queue pointers, drop flag and the rate-limited output scheduler
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      gap_q        <= '0;
      overflow     <= 1'b0;
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (live_ev && !live_push) begin
        overflow <= 1'b1;
      end
      key_strobe <= pop_c;
      if (pop_c) begin
        rd_ptr       <= rd_ptr + (PTR_W + 1)'(1);
        key_code     <= head.code;
        key_pressed  <= head.pressed;
        key_extended <= head.extended;
        gap_q        <= GAP_W'(GAP_CYCLES - 1);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_event_sequencer.sv
// Scoreboard bench for key_event_sequencer: directed byte streams with hand-computed
// expected strobes, checked by an independent strobe monitor.
module tb_key_event_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_valid;
  logic [7:0] ps2_data;
  logic       inj_valid;
  logic [7:0] inj_code;
  logic       inj_pressed;
  logic       inj_extended;
  logic       inj_ready;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       overflow;

  always #5 clk_sys = ~clk_sys;

  key_event_sequencer #(
    .FIFO_DEPTH(8),
    .GAP_CYCLES(64),
    .PREFIX_TIMEOUT(4096)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_valid(ps2_valid),
    .ps2_data(ps2_data),
    .inj_valid(inj_valid),
    .inj_code(inj_code),
    .inj_pressed(inj_pressed),
    .inj_extended(inj_extended),
    .inj_ready(inj_ready),
    .key_strobe(key_strobe),
    .key_pressed(key_pressed),
    .key_extended(key_extended),
    .key_code(key_code),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  strobe_total = 0;
  int  last_strobe_cyc = 0;
  int  prev_strobe_cyc = 0;
  int  last_valid_cyc = 0;
  logic [7:0] burst [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor: every strobe is matched against the oldest expected event
  always @(negedge clk_sys) begin
    if (key_strobe === 1'b1) begin
      ev_t e;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_total++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got code=%h pressed=%b ext=%b, expected no strobe",
                 key_code, key_pressed, key_extended);
      end else begin
        e = exp_q.pop_front();
        if ({key_code, key_pressed, key_extended} !== e) begin
          fails++;
          $display("FAIL strobe_event: got code=%h pressed=%b ext=%b, expected code=%h pressed=%b ext=%b",
                   key_code, key_pressed, key_extended, e.code, e.pressed, e.ext);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic p, input logic e);
    ev_t ev;
    ev.code = code;
    ev.pressed = p;
    ev.ext = e;
    exp_q.push_back(ev);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_sys);
    #1;
    ps2_valid = 1'b1;
    ps2_data = b;
    last_valid_cyc = cyc;
    @(posedge clk_sys);
    #1;
    ps2_valid = 1'b0;
  endtask

  task automatic wait_total(input int target, input int budget, input string name);
    int n = 0;
    while (strobe_total < target && n < budget) begin
      @(posedge clk_sys);
      n++;
    end
    if (strobe_total < target) chk(name, strobe_total, target);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_strobe"}, key_strobe, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_pressed"}, key_pressed, 0);
    chk({tag, "_extended"}, key_extended, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_inj_ready"}, inj_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ps2_valid = 1'b0;
    ps2_data = 8'h00;
    inj_valid = 1'b0;
    inj_code = 8'h00;
    inj_pressed = 1'b0;
    inj_extended = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_outputs_zero("reset");
    @(posedge clk_sys);
    #1;
    reset = 1'b0;

    // Plain make, then break; make latency from ps2_valid is 2 cycles
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    wait_total(1, 20, "make_wait");
    chk("make_latency", last_strobe_cyc - last_valid_cyc, 2);
    idle(70);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_total(2, 20, "break_wait");
    idle(3);
    @(negedge clk_sys);
    chk("hold_code", key_code, 8'h1C);
    chk("hold_pressed", key_pressed, 0);
    chk("hold_strobe_low", key_strobe, 0);

    // Extended make/break queued back to back: strobes exactly 64 cycles apart
    idle(70);
    expect_ev(8'h75, 1'b1, 1'b1);
    expect_ev(8'h75, 1'b0, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    wait_total(4, 200, "ext_wait");
    chk("gap_spacing", last_strobe_cyc - prev_strobe_cyc, 64);

    // Pause sequence swallowed, following key passes, AA dropped
    idle(70);
    expect_ev(8'h16, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    send_byte(8'h16);
    send_byte(8'hAA);
    idle(100);
    chk("pause_strobe_count", strobe_total, 5);
    chk("pause_queue_empty", exp_q.size(), 0);

    // Stale E0 prefix expires
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_byte(8'hE0);
    idle(4100);
    send_byte(8'h1C);
    wait_total(6, 20, "timeout_wait");

    // Injection loses to a live write in the same cycle, then follows it
    idle(70);
    expect_ev(8'h1C, 1'b1, 1'b0);
    expect_ev(8'h5A, 1'b1, 1'b0);
    @(posedge clk_sys);
    #1;
    ps2_valid = 1'b1;
    ps2_data = 8'h1C;
    inj_valid = 1'b1;
    inj_code = 8'h5A;
    inj_pressed = 1'b1;
    inj_extended = 1'b0;
    @(negedge clk_sys);
    chk("inj_ready_live", inj_ready, 0);
    @(posedge clk_sys);
    #1;
    ps2_valid = 1'b0;
    @(negedge clk_sys);
    chk("inj_ready_free", inj_ready, 1);
    @(posedge clk_sys);
    #1;
    inj_valid = 1'b0;
    wait_total(8, 200, "inj_wait");

    // Fill the queue during a gap, ninth live event is dropped
    idle(70);
    expect_ev(8'h1B, 1'b1, 1'b0);
    send_byte(8'h1B);
    wait_total(9, 20, "fill_first_wait");
    @(negedge clk_sys);
    chk("overflow_before", overflow, 0);
    for (int i = 0; i < 8; i++) expect_ev(burst[i], 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk_sys);
      #1;
      ps2_valid = 1'b1;
      ps2_data = burst[i];
    end
    @(posedge clk_sys);
    #1;
    ps2_valid = 1'b0;
    @(negedge clk_sys);
    chk("overflow_set", overflow, 1);
    chk("inj_ready_full", inj_ready, 0);
    wait_total(17, 1000, "fill_drain_wait");
    idle(100);
    chk("fill_strobe_count", strobe_total, 17);
    chk("fill_queue_empty", exp_q.size(), 0);

    // Reset with events queued and parser in E0F0
    idle(70);
    expect_ev(8'h1B, 1'b1, 1'b0);
    send_byte(8'h1B);
    wait_total(18, 20, "prereset_wait");
    send_byte(8'h15);
    send_byte(8'h1D);
    send_byte(8'h24);
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(posedge clk_sys);
    #1;
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk_outputs_zero("midreset");
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    idle(100);
    chk("postreset_no_strobe", strobe_total, 18);
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    wait_total(19, 20, "postreset_wait");
    idle(5);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_event_sequencer.md
Name: key_event_sequencer

Overview:
- Sits between the PS/2 receiver and the Oric keyboard matrix.
- Parses raw PS/2 set-2 bytes (E0 / F0 / E1 prefixes) into key events.
- Arbitrates those live events against a synthetic-keystroke injection port used by autotype and the OSD.
- Queues all events and emits them as rate-limited single-cycle strobes on the matrix's key_strobe/key_pressed/key_extended/key_code inputs.

Parameters:
FIFO_DEPTH, 8, event queue entries (power of two, ≥2)
GAP_CYCLES, 64, minimum clk_sys cycles from one key_strobe to the next (≥1)
PREFIX_TIMEOUT, 4096, idle cycles after which a pending prefix is discarded

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_valid  in  1  one-cycle pulse, ps2_data holds a received byte
ps2_data  in  8  raw scancode byte
inj_valid  in  1  injection request
inj_code  in  8  injected scancode
inj_pressed  in  1  injected make(1)/break(0)
inj_extended  in  1  injected E0 flag
inj_ready  out  1  injection accepted this cycle when inj_valid & inj_ready
key_strobe  out  1  one-cycle event pulse to matrix
key_pressed  out  1  event make/break
key_extended  out  1  event E0 flag
key_code  out  8  event scancode
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0, parser in IDLE, FIFO empty, gap counter 0, timeout counter 0. Reset mid-operation discards queued events and any pending prefix. The matrix's latched key states are not cleared by this block.
- Parser FSM, states IDLE, E0, F0, E0F0, SKIP. Acts only on cycles with ps2_valid:
  - IDLE: E0→E0; F0→F0; E1→SKIP (skip counter = 7); AA, FA, FE, EE, 00 and FF are dropped; any other byte→event {code, pressed=1, ext=0}, stay IDLE.
  - E0: F0→E0F0; E0 stays E0; other byte→event {code, 1, 1}, →IDLE.
  - F0: any byte→event {code, 0, 0}, →IDLE.
  - E0F0: any byte→event {code, 0, 1}, →IDLE.
  - SKIP: each byte decrements the skip counter; at 0 (the 7th byte consumed) →IDLE. No events are produced (Pause is ignored).
- Timeout counter runs while the parser is not in IDLE. It clears on every ps2_valid. When it reaches PREFIX_TIMEOUT-1, the parser returns to IDLE on the next cycle with no event.
- Event arbitration into the FIFO:
  - A parsed live event always has priority and is written in the cycle after its ps2_valid (1-cycle parse latency).
  - inj_ready = FIFO not full AND no live write this cycle AND not reset.
  - An injection handshake writes {inj_code, inj_pressed, inj_extended} the same cycle.
  - Live event with FIFO full: dropped, overflow set to 1 until reset. An injection is never dropped because it waits on inj_ready.
- FIFO: FIFO_DEPTH entries of 10 bits. Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit. A simultaneous push and pop when full is allowed (the pop frees the slot first).
- Output scheduler:
  - The gap counter decrements to 0 and saturates there.
  - When the FIFO is not empty and gap==0: pop, register the entry onto key_code/key_pressed/key_extended, pulse key_strobe for exactly 1 cycle, load gap=GAP_CYCLES-1.
  - Data outputs hold their value until the next strobe.
  - An event written to an empty FIFO with gap==0 strobes 1 cycle after the write, giving 2 cycles from ps2_valid.
  - Events leave in write order.

Test Plan:
- Bytes 1C, then (after ≥GAP) F0 1C → strobe {1C, pressed=1, ext=0}, then {1C, 0, 0}; ps2_valid for 1C to strobe = 2 cycles.
- Bytes E0 75, E0 F0 75 → strobes {75,1,1} then {75,0,1}, spaced exactly GAP_CYCLES=64 cycles apart when queued back-to-back.
- E1 14 77 E1 F0 14 F0 77, then 16 → only one strobe {16,1,0}. Byte AA alone → no strobe.
- E0, then 4096 idle cycles, then 1C → strobe {1C,1,0} (prefix expired, ext=0).
- With inj_valid held and a live byte landing on the same cycle → inj_ready=0 that cycle. Live event precedes the injected one in strobe order. Fill 8 entries, then a 9th live event → overflow=1, 8 strobes only.
- Reset asserted while 3 events are queued and the parser is in E0F0 → no further strobes, all outputs 0, overflow 0. Next byte 1C → {1C,1,0}.
